// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and the common character width.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, with wrap.
module rr_pick #(
  parameter int NREQ    = 4,
  parameter int id_bits = 2
) (
  input  logic [NREQ-1:0]    req,
  input  logic [id_bits-1:0] ptr,
  output logic [NREQ-1:0]    sel,
  output logic               valid
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    sel   = '0;
    valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!valid && req[(int'(ptr) + i) % NREQ]) begin
        sel[(int'(ptr) + i) % NREQ] = 1'b1;
        valid                       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NREQ requesters: round-robin grant, start strobe,
// wait for frame completion with a watchdog, then a one-cycle gap.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int                      data_bits    = DATA_BITS,
  parameter int                      NREQ         = 4,
  parameter int                      id_bits      = 2,
  parameter int                      timeout_bits = 16,
  parameter logic [timeout_bits-1:0] TIMEOUT      = 16'hFFFF
) (
  input  logic                      sysclk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*data_bits-1:0] req_data,
  output logic [NREQ-1:0]           req_ack,
  output logic [NREQ-1:0]           req_done,
  output logic [NREQ-1:0]           req_err,
  output logic [data_bits-1:0]      DBUS,
  output logic                      txd_startH,
  input  logic                      txd_doneH,
  output logic                      busy,
  output logic [id_bits-1:0]        grant_id
);

  localparam logic [timeout_bits-1:0] WD_LAST = TIMEOUT - 1'b1;
  localparam logic [id_bits-1:0]      PTR_LAST = id_bits'(NREQ - 1);

  logic [1:0]              state;
  logic [id_bits-1:0]      ptr;
  logic [timeout_bits-1:0] wd;

  logic [NREQ-1:0]         pick_sel;
  logic                    pick_valid;
  logic [id_bits-1:0]      pick_idx;
  logic [data_bits-1:0]    pick_data;
  logic [NREQ-1:0]         grant_onehot;
  logic [id_bits-1:0]      next_ptr;

  rr_pick #(
    .NREQ    (NREQ),
    .id_bits (id_bits)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .sel   (pick_sel),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_sel[i]) pick_idx = id_bits'(i);
    end
  end

  assign pick_data    = req_data[pick_idx*data_bits +: data_bits];
  assign grant_onehot = {{(NREQ-1){1'b0}}, 1'b1} << grant_id;
  assign next_ptr     = (grant_id == PTR_LAST) ? '0 : grant_id + 1'b1;
  assign busy         = (state != S_IDLE);

  // NOTE: all state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      wd         <= '0;
      DBUS       <= '0;
      txd_startH <= 1'b0;
      req_ack    <= '0;
      req_done   <= '0;
      req_err    <= '0;
      grant_id   <= '0;
    end else begin
      req_ack    <= '0;
      req_done   <= '0;
      req_err    <= '0;
      txd_startH <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            DBUS     <= pick_data;
            grant_id <= pick_idx;
            req_ack  <= pick_sel;
            state    <= S_START;
          end
        end
        S_START: begin
          txd_startH <= 1'b1;
          wd         <= '0;
          state      <= S_BUSY;
        end
        S_BUSY: begin
          // Completion outranks a watchdog expiry in the same cycle.
          if (txd_doneH) begin
            req_done <= grant_onehot;
            ptr      <= next_ptr;
            state    <= S_GAP;
          end else if (wd == WD_LAST) begin
            req_done <= grant_onehot;
            req_err  <= grant_onehot;
            ptr      <= next_ptr;
            state    <= S_GAP;
          end else if (wd != '1) begin
            wd <= wd + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small uart_tx response model.
module tb_uart_tx_arbiter;

  logic        sysclk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_ack, req_done, req_err;
  logic [7:0]  DBUS;
  logic        txd_startH;
  logic        txd_doneH;
  logic        busy;
  logic [1:0]  grant_id;

  int n_checks = 0;
  int n_pass   = 0;
  bit model_en = 1'b1;
  int model_delay = 4;

  always #5 sysclk = ~sysclk;

  uart_tx_arbiter #(
    .data_bits    (8),
    .NREQ         (4),
    .id_bits      (2),
    .timeout_bits (16),
    .TIMEOUT      (16'd20)
  ) dut (
    .sysclk     (sysclk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .req_ack    (req_ack),
    .req_done   (req_done),
    .req_err    (req_err),
    .DBUS       (DBUS),
    .txd_startH (txd_startH),
    .txd_doneH  (txd_doneH),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  // uart_tx model: pulses txd_doneH so that it is sampled model_delay+1 edges after start.
  initial begin
    txd_doneH = 1'b0;
    forever begin
      @(negedge sysclk);
      if (txd_startH && model_en) begin
        repeat (model_delay) @(negedge sysclk);
        txd_doneH = 1'b1;
        @(negedge sysclk);
        txd_doneH = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  exp_ack;
    logic [1:0]  exp_id;
    logic [7:0]  exp_dbus;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // which: 0 = req_ack, 1 = req_done, 2 = txd_startH
  task automatic wait_for(input int which, input int limit, input string name, output int cyc);
    logic hit;
    hit = 1'b0;
    cyc = 0;
    for (int i = 1; i <= limit && !hit; i++) begin
      @(negedge sysclk);
      cyc = i;
      case (which)
        0:       hit = |req_ack;
        1:       hit = |req_done;
        default: hit = txd_startH;
      endcase
    end
    check({name, "_seen"}, {31'd0, hit}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    req      = v.req;
    req_data = v.data;
    wait_for(0, 10, {tag, "_ack"}, cyc);
    check({tag, "_ack_lat"}, cyc, 1);
    check({tag, "_ack"}, {28'd0, req_ack}, {28'd0, v.exp_ack});
    check({tag, "_grant"}, {30'd0, grant_id}, {30'd0, v.exp_id});
    check({tag, "_dbus"}, {24'd0, DBUS}, {24'd0, v.exp_dbus});
    req      = '0;
    req_data = ~v.data;
    @(negedge sysclk);
    check({tag, "_start_hi"}, {31'd0, txd_startH}, 32'd1);
    @(negedge sysclk);
    check({tag, "_start_lo"}, {31'd0, txd_startH}, 32'd0);
    check({tag, "_dbus_hold"}, {24'd0, DBUS}, {24'd0, v.exp_dbus});
    wait_for(1, 40, {tag, "_done"}, cyc);
    check({tag, "_done"}, {28'd0, req_done}, {28'd0, v.exp_ack});
    check({tag, "_err"}, {28'd0, req_err}, 32'd0);
    check({tag, "_busy_gap"}, {31'd0, busy}, 32'd1);
    @(negedge sysclk);
    check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
  endtask

  vec_t vecs[7];
  vec_t extra;
  logic [7:0] cont_bytes[5];
  logic [1:0] cont_ids[5];

  initial begin
    int cyc;
    int acks;

    vecs[0] = '{req: 4'b0100, data: 32'h00A5_0000, exp_ack: 4'b0100, exp_id: 2'd2, exp_dbus: 8'hA5};
    vecs[1] = '{req: 4'b0011, data: 32'h0000_2211, exp_ack: 4'b0001, exp_id: 2'd0, exp_dbus: 8'h11};
    vecs[2] = '{req: 4'b0011, data: 32'h0000_4433, exp_ack: 4'b0010, exp_id: 2'd1, exp_dbus: 8'h44};
    vecs[3] = '{req: 4'b1000, data: 32'h3C00_0000, exp_ack: 4'b1000, exp_id: 2'd3, exp_dbus: 8'h3C};
    vecs[4] = '{req: 4'b1001, data: 32'h5500_0066, exp_ack: 4'b0001, exp_id: 2'd0, exp_dbus: 8'h66};
    vecs[5] = '{req: 4'b1001, data: 32'h7700_0088, exp_ack: 4'b1000, exp_id: 2'd3, exp_dbus: 8'h77};
    vecs[6] = '{req: 4'b1111, data: 32'h9ABC_DEF0, exp_ack: 4'b0001, exp_id: 2'd0, exp_dbus: 8'hF0};
    cont_bytes = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    cont_ids   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    repeat (3) @(negedge sysclk);
    check("rst_dbus", {24'd0, DBUS}, 32'd0);
    check("rst_start", {31'd0, txd_startH}, 32'd0);
    check("rst_ack", {28'd0, req_ack}, 32'd0);
    check("rst_done", {28'd0, req_done}, 32'd0);
    check("rst_err", {28'd0, req_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_grant", {30'd0, grant_id}, 32'd0);
    rst = 1'b0;
    @(negedge sysclk);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // All four requesters held continuously from a freshly reset pointer.
    rst = 1'b1;
    @(negedge sysclk);
    rst      = 1'b0;
    req      = 4'b1111;
    req_data = 32'h1312_1110;
    for (int k = 0; k < 5; k++) begin
      wait_for(0, 10, "cont_ack", cyc);
      check($sformatf("cont%0d_spacing", k), cyc, (k == 0) ? 1 : 2);
      check($sformatf("cont%0d_grant", k), {30'd0, grant_id}, {30'd0, cont_ids[k]});
      check($sformatf("cont%0d_dbus", k), {24'd0, DBUS}, {24'd0, cont_bytes[k]});
      wait_for(1, 40, "cont_done", cyc);
      if (k == 4) req = '0;
    end
    repeat (2) @(negedge sysclk);

    // A request that drops while the arbiter is busy is never served.
    req      = 4'b0100;
    req_data = 32'h00C3_0000;
    wait_for(0, 10, "blip_ack", cyc);
    check("blip_ack", {28'd0, req_ack}, 32'b0100);
    req = 4'b0010;
    @(negedge sysclk);
    req = '0;
    wait_for(1, 40, "blip_done", cyc);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge sysclk);
      if (|req_ack) acks++;
    end
    check("blip_no_ack", acks, 0);
    check("blip_grant", {30'd0, grant_id}, 32'd2);

    // Watchdog: the model stays silent, abort lands 20 cycles after the start cycle.
    model_en = 1'b0;
    req      = 4'b0010;
    req_data = 32'h0000_5A00;
    wait_for(0, 10, "wd_ack", cyc);
    check("wd_ack", {28'd0, req_ack}, 32'b0010);
    req = '0;
    wait_for(2, 5, "wd_start", cyc);
    wait_for(1, 40, "wd_done", cyc);
    check("wd_delay", cyc, 20);
    check("wd_done", {28'd0, req_done}, 32'b0010);
    check("wd_err", {28'd0, req_err}, 32'b0010);
    check("wd_busy_gap", {31'd0, busy}, 32'd1);
    @(negedge sysclk);
    check("wd_busy_idle", {31'd0, busy}, 32'd0);
    model_en = 1'b1;
    extra = '{req: 4'b0011, data: 32'h0000_D2D1, exp_ack: 4'b0001, exp_id: 2'd0, exp_dbus: 8'hD1};
    run_vec(extra, "post_wd");

    // Completion arriving in the very expiry cycle.
    model_delay = 19;
    req         = 4'b1000;
    req_data    = 32'hE100_0000;
    wait_for(0, 10, "col_ack", cyc);
    check("col_ack", {28'd0, req_ack}, 32'b1000);
    req = '0;
    wait_for(2, 5, "col_start", cyc);
    wait_for(1, 40, "col_done", cyc);
    check("col_delay", cyc, 20);
    check("col_done", {28'd0, req_done}, 32'b1000);
    check("col_err", {28'd0, req_err}, 32'd0);
    model_delay = 4;
    repeat (3) @(negedge sysclk);

    // Reset while BUSY with the request still held.
    model_en = 1'b0;
    req      = 4'b0100;
    req_data = 32'h00B7_0000;
    wait_for(0, 10, "rb_ack", cyc);
    wait_for(2, 5, "rb_start", cyc);
    repeat (3) @(negedge sysclk);
    check("rb_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge sysclk);
    rst = 1'b0;
    check("rb_start", {31'd0, txd_startH}, 32'd0);
    check("rb_busy", {31'd0, busy}, 32'd0);
    check("rb_grant", {30'd0, grant_id}, 32'd0);
    check("rb_done", {28'd0, req_done}, 32'd0);
    wait_for(0, 5, "rb_reack", cyc);
    check("rb_reack_lat", cyc, 1);
    check("rb_reack", {28'd0, req_ack}, 32'b0100);
    check("rb_reack_done", {28'd0, req_done}, 32'd0);
    check("rb_dbus", {24'd0, DBUS}, 32'hB7);
    req = '0;
    rst = 1'b1;
    repeat (2) @(negedge sysclk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
